kpyd_debouncer_array: RTL and testbench
=======================================

Name: kpyd_debouncer_array

Overview:
Multi-channel, parametrised debouncer for the keypad front end. Each channel synchronises one raw key line and filters it through a saturating up/down integrator with hysteresis. Each channel produces a clean level plus one-cycle rise/fall pulses. Debounced transitions are queued as per-channel pending events and reported to the keypad scanner/decoder over a ready/valid interface, with lowest-index priority and overrun detection.

Parameters:
channels_p, 16, number of independent key lines (4x4 keypad); must be >= 1
width_p, 10, integrator counter width; saturation max = 2^width_p - 1; must be >= 1
sync_stages_p, 2, synchroniser flops per channel; must be >= 1
id_width_lp, max(1, $clog2(channels_p)), localparam, width of event_id_o

Ports:
clk_i  input  1  system clock
reset_i  input  1  asynchronous, active-high reset
tick_i  input  1  sample enable; integrators update only when 1 (tie high for per-cycle operation)
press_i  input  channels_p  raw asynchronous key lines, 1 = pressed
debounced_o  output  channels_p  filtered key levels, registered
rise_o  output  channels_p  one-cycle pulse when debounced_o[i] goes 0->1
fall_o  output  channels_p  one-cycle pulse when debounced_o[i] goes 1->0
event_v_o  output  1  a pending event is presented
event_ready_i  input  1  consumer accepts the event when event_v_o & event_ready_i at a rising edge
event_id_o  output  id_width_lp  channel index of the presented event
event_press_o  output  1  1 = press event, 0 = release event
overrun_o  output  1  sticky: an unconsumed event was overwritten; cleared only by reset

Behaviour:
- Reset: on reset_i assertion, asynchronously clear every state element. This includes sync flops, counters, debounced_o, rise_o, fall_o, pending bits, types and overrun_o. All outputs are 0 while reset_i is high, including event_v_o. Reset mid-count discards all progress.
- Synchroniser: press_i[i] passes through sync_stages_p flops. s[i] denotes the last stage. It updates every cycle, independent of tick_i.
- Integrator cnt[i] (width_p bits), updated only on edges where tick_i = 1:
  - s=1 and cnt < max: cnt+1. s=1 and cnt = max: hold.
  - s=0 and cnt > 0: cnt-1. s=0 and cnt = 0: hold.
  - Never wraps.
- Level register: debounced_o[i] next = 1 if cnt[i]==max, 0 if cnt[i]==0, else hold. It is evaluated every edge on the registered cnt, which gives the hysteresis.
- Pulses: rise_o[i] / fall_o[i] are registered and asserted in the same cycle debounced_o[i] changes, for exactly one cycle.
- Latency (tick_i=1, cnt=0, press_i stable 1 before edge E1): s=1 after edge E(sync_stages_p); cnt=max after edge E(sync_stages_p+2^width_p-1); debounced_o=1 after edge E(sync_stages_p+2^width_p). Release is symmetric from cnt=max. With width_p=4 and sync_stages_p=2, the level rises after the 18th edge.
- Glitch: any input pulse shorter than needed to reach max/0 never changes debounced_o.
- Event queue, per channel pend[i] and typ[i]:
  - A rise or fall sets pend[i]=1 and typ[i]=1 (rise) or 0 (fall).
  - event_v_o = OR of pend. The presented channel is the lowest index with pend=1, with event_id_o = that index and event_press_o = its typ. Outputs are combinational from registers only; no combinational path from event_ready_i.
  - Accept (event_v_o & event_ready_i): clear pend of the presented channel on that edge.
  - New edge while pend[i]=1 and not being accepted: typ[i] is overwritten with the newest type, pend stays 1, and overrun_o is set.
  - New edge on the same channel at the same edge as its accept: pend stays 1 with the new type; no overrun.
  - Events on different channels never interfere. Starvation of high indices under continuous low-index activity is accepted behaviour.

Test Plan:
1. Params channels_p=4, width_p=4, sync_stages_p=2, tick_i=1, ready=1; press_i[0]=1 held. Required: debounced_o[0]=1 after the 18th edge; rise_o[0] high for exactly 1 cycle; event_v_o=1 with id=0, press=1 for 1 cycle. Then release: debounced_o[0]=0 after 18 edges; fall_o pulse; event with press=0.
2. Glitch: press_i[1]=1 for 6 cycles, then 0. Required: debounced_o, rise_o and event_v_o stay 0; cnt returns to 0 with no underflow wrap.
3. tick_i high every 4th cycle, press_i[2]=1 held. Required: debounced_o[2] rises only after 15 ticks have driven cnt to max, plus 1 edge; cnt frozen between ticks.
4. press_i[1] and press_i[3] rise on the same cycle, ready=1. Required: id=1 presented first, id=3 on the next cycle; overrun_o=0.
5. ready=0; channel 2 pressed, then released after debounce. Required: single pending event id=2 with press=0, and overrun_o=1. Raise ready: one accept, event_v_o falls, overrun_o stays 1.
6. Hold press_i[0]=1 until cnt=9, then assert reset_i for 3 cycles mid-count. Required: all outputs 0 immediately. After release, the full 18-edge latency restarts from cnt=0.

Source files
------------

// File: rtl/kpyd_debouncer_array.sv
// Multi-channel keypad debouncer: per-line synchroniser, saturating integrator
// with hysteresis, edge pulses, and a lowest-index-first pending event queue.
module kpyd_debouncer_array #(
    parameter int unsigned channels_p    = 16,
    parameter int unsigned width_p       = 10,
    parameter int unsigned sync_stages_p = 2,
    localparam int unsigned id_width_lp  = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   tick_i,
    input  logic [channels_p-1:0]  press_i,
    output logic [channels_p-1:0]  debounced_o,
    output logic [channels_p-1:0]  rise_o,
    output logic [channels_p-1:0]  fall_o,
    output logic                   event_v_o,
    input  logic                   event_ready_i,
    output logic [id_width_lp-1:0] event_id_o,
    output logic                   event_press_o,
    output logic                   overrun_o
);

    localparam logic [width_p-1:0] cnt_max_lp = {width_p{1'b1}};

    logic [channels_p-1:0] sync_q [sync_stages_p];
    logic [width_p-1:0]    cnt_q  [channels_p];
    logic [channels_p-1:0] samp;
    logic [channels_p-1:0] deb_nxt;
    logic [channels_p-1:0] rise_nxt;
    logic [channels_p-1:0] fall_nxt;
    logic [channels_p-1:0] edge_nxt;
    logic [channels_p-1:0] pend_q;
    logic [channels_p-1:0] typ_q;
    logic [channels_p-1:0] sel_oh;
    logic [channels_p-1:0] accept_oh;
    logic [id_width_lp-1:0] sel_id;
    logic                  ovr_set;

    assign samp = sync_q[sync_stages_p-1];

    // Synchroniser chain, runs every cycle regardless of tick_i
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < sync_stages_p; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= press_i;
            for (int unsigned k = 1; k < sync_stages_p; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Saturating up/down integrators, advanced on tick only
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < channels_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (tick_i) begin
            for (int unsigned i = 0; i < channels_p; i++) begin
                if (samp[i] && (cnt_q[i] != cnt_max_lp)) begin
                    cnt_q[i] <= cnt_q[i] + width_p'(1);
                end else if (!samp[i] && (cnt_q[i] != '0)) begin
                    cnt_q[i] <= cnt_q[i] - width_p'(1);
                end
            end
        end
    end

    // Hysteresis: level only moves at the rails of the integrator
    always_comb begin
        deb_nxt = debounced_o;
        for (int unsigned i = 0; i < channels_p; i++) begin
            if (cnt_q[i] == cnt_max_lp) begin
                deb_nxt[i] = 1'b1;
            end else if (cnt_q[i] == '0) begin
                deb_nxt[i] = 1'b0;
            end
        end
    end

    assign rise_nxt = deb_nxt & ~debounced_o;
    assign fall_nxt = ~deb_nxt & debounced_o;
    assign edge_nxt = rise_nxt | fall_nxt;

    // Lowest pending index wins; presentation depends on registers only
    always_comb begin
        sel_id = '0;
        for (int i = int'(channels_p) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_id = id_width_lp'(i);
            end
        end
    end

    assign sel_oh        = pend_q & (~pend_q + channels_p'(1));
    assign event_v_o     = |pend_q;
    assign event_id_o    = sel_id;
    assign event_press_o = |(typ_q & sel_oh);
    assign accept_oh     = sel_oh & {channels_p{event_v_o & event_ready_i}};
    assign ovr_set       = |(edge_nxt & pend_q & ~accept_oh);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            debounced_o <= '0;
            rise_o      <= '0;
            fall_o      <= '0;
            pend_q      <= '0;
            typ_q       <= '0;
            overrun_o   <= 1'b0;
        end else begin
            debounced_o <= deb_nxt;
            rise_o      <= rise_nxt;
            fall_o      <= fall_nxt;
            pend_q      <= edge_nxt | (pend_q & ~accept_oh);
            typ_q       <= (typ_q & ~edge_nxt) | rise_nxt;
            overrun_o   <= overrun_o | ovr_set;
        end
    end

endmodule

// File: tb/tb_kpyd_debouncer_array.sv
// Bench for kpyd_debouncer_array: behavioural model checked every cycle plus
// directed scenarios with hand-computed latencies and event ordering.
module tb_kpyd_debouncer_array;

    localparam int CH   = 4;
    localparam int W    = 4;
    localparam int SS   = 2;
    localparam int MAXC = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          tick;
    logic [CH-1:0] press;
    logic [CH-1:0] debounced;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          ev_v;
    logic          ready;
    logic [1:0]    ev_id;
    logic          ev_press;
    logic          overrun;

    int vectors;
    int miscompares;

    kpyd_debouncer_array #(
        .channels_p   (CH),
        .width_p      (W),
        .sync_stages_p(SS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .tick_i       (tick),
        .press_i      (press),
        .debounced_o  (debounced),
        .rise_o       (rise),
        .fall_o       (fall),
        .event_v_o    (ev_v),
        .event_ready_i(ready),
        .event_id_o   (ev_id),
        .event_press_o(ev_press),
        .overrun_o    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int            m_cnt  [CH];
    bit            m_deb  [CH];
    bit            m_rise [CH];
    bit            m_fall [CH];
    bit            m_pend [CH];
    bit            m_typ  [CH];
    bit            m_ovr;
    logic [CH-1:0] hist[$];

    task automatic model_clear();
        for (int i = 0; i < CH; i++) begin
            m_cnt[i] = 0; m_deb[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
            m_pend[i] = 0; m_typ[i] = 0;
        end
        m_ovr = 0;
        hist.delete();
    endtask

    function automatic int model_sel();
        for (int i = 0; i < CH; i++) begin
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [CH-1:0] s_old;
        int  sel;
        bit  acc;
        bit  lvl;
        bit  ev;
        if (rst) begin
            model_clear();
            return;
        end
        s_old = (hist.size() >= SS) ? hist[SS-1] : '0;
        sel   = model_sel();
        acc   = (sel >= 0) && ready;
        for (int i = 0; i < CH; i++) begin
            lvl = (m_cnt[i] == MAXC) ? 1'b1 : (m_cnt[i] == 0) ? 1'b0 : m_deb[i];
            m_rise[i] = lvl && !m_deb[i];
            m_fall[i] = !lvl && m_deb[i];
            m_deb[i]  = lvl;
            if (tick) begin
                if (s_old[i]) m_cnt[i] = (m_cnt[i] + 1 > MAXC) ? MAXC : m_cnt[i] + 1;
                else          m_cnt[i] = (m_cnt[i] - 1 < 0) ? 0 : m_cnt[i] - 1;
            end
            ev = m_rise[i] || m_fall[i];
            if (ev) begin
                if (m_pend[i] && !(acc && sel == i)) m_ovr = 1;
                m_pend[i] = 1;
                m_typ[i]  = m_rise[i];
            end else if (acc && sel == i) begin
                m_pend[i] = 0;
            end
        end
        hist.push_front(press);
        if (hist.size() > SS) void'(hist.pop_back());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [CH-1:0] e_deb, e_rise, e_fall;
        int sel;
        if (rst) begin
            chk("rst_deb", int'(debounced), 0);
            chk("rst_pulses", int'(rise | fall), 0);
            chk("rst_ev_v", int'(ev_v), 0);
            chk("rst_ovr", int'(overrun), 0);
            return;
        end
        for (int i = 0; i < CH; i++) begin
            e_deb[i] = m_deb[i]; e_rise[i] = m_rise[i]; e_fall[i] = m_fall[i];
        end
        sel = model_sel();
        chk("deb", int'(debounced), int'(e_deb));
        chk("rise", int'(rise), int'(e_rise));
        chk("fall", int'(fall), int'(e_fall));
        chk("ev_v", int'(ev_v), (sel >= 0) ? 1 : 0);
        if (sel >= 0) begin
            chk("ev_id", int'(ev_id), sel);
            chk("ev_press", int'(ev_press), int'(m_typ[sel]));
        end
        chk("ovr", int'(overrun), int'(m_ovr));
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        #20;
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_deb(input int ch, input logic val, input int limit, output int n);
        n = 0;
        while (debounced[ch] !== val && n < limit) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  bad;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b0;
        press = '0;
        tick  = 1'b1;
        ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("reset_state_deb", int'(debounced), 0);
        chk("reset_state_ev", int'(ev_v), 0);
        chk("reset_state_ovr", int'(overrun), 0);
        step(3);
        rst = 1'b0;

        // 1: press/release latency on channel 0
        press[0] = 1'b1;
        wait_deb(0, 1'b1, 40, n);
        chk("t1_rise_latency", n, 18);
        chk("t1_rise_pulse", int'(rise), 1);
        chk("t1_ev_v", int'(ev_v), 1);
        chk("t1_ev_id", int'(ev_id), 0);
        chk("t1_ev_press", int'(ev_press), 1);
        step(1);
        chk("t1_rise_one_cycle", int'(rise), 0);
        chk("t1_ev_consumed", int'(ev_v), 0);
        press[0] = 1'b0;
        wait_deb(0, 1'b0, 40, n);
        chk("t1_fall_latency", n, 18);
        chk("t1_fall_pulse", int'(fall), 1);
        chk("t1_rel_ev_press", int'(ev_press), 0);
        chk("t1_rel_ev_v", int'(ev_v), 1);
        step(1);
        chk("t1_fall_one_cycle", int'(fall), 0);

        // 2: 6-cycle glitch on channel 1
        press[1] = 1'b1;
        step(6);
        press[1] = 1'b0;
        bad = 0;
        for (int k = 0; k < 24; k++) begin
            step(1);
            if (debounced[1] || rise[1] || ev_v) bad = 1;
        end
        chk("t2_glitch_quiet", int'(bad), 0);
        chk("t2_model_cnt_zero", m_cnt[1], 0);

        // 3: sparse tick on channel 2
        tick = 1'b0;
        press[2] = 1'b1;
        step(3);
        for (int t = 1; t <= 15; t++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            chk("t3_no_early_rise", int'(debounced[2]), 0);
            if (t < 15) begin
                step(3);
                chk("t3_cnt_frozen", m_cnt[2], t);
            end
        end
        chk("t3_model_cnt_max", m_cnt[2], 15);
        step(1);
        chk("t3_rise_after_15_ticks", int'(debounced[2]), 1);
        chk("t3_ev_id", int'(ev_id), 2);
        tick = 1'b1;
        press[2] = 1'b0;
        wait_deb(2, 1'b0, 40, n);
        chk("t3_release_latency", n, 18);
        step(2);

        // 4: simultaneous presses on channels 1 and 3
        press[1] = 1'b1;
        press[3] = 1'b1;
        wait_deb(1, 1'b1, 40, n);
        chk("t4_latency", n, 18);
        chk("t4_both_deb", int'(debounced), 4'b1010);
        chk("t4_first_id", int'(ev_id), 1);
        chk("t4_first_v", int'(ev_v), 1);
        step(1);
        chk("t4_second_v", int'(ev_v), 1);
        chk("t4_second_id", int'(ev_id), 3);
        step(1);
        chk("t4_drained", int'(ev_v), 0);
        chk("t4_no_overrun", int'(overrun), 0);
        press[1] = 1'b0;
        press[3] = 1'b0;
        wait_deb(3, 1'b0, 40, n);
        step(3);

        // 5: overrun with the consumer stalled
        ready = 1'b0;
        press[2] = 1'b1;
        wait_deb(2, 1'b1, 40, n);
        chk("t5_press_latency", n, 18);
        chk("t5_pend_press", int'(ev_press), 1);
        chk("t5_no_ovr_yet", int'(overrun), 0);
        press[2] = 1'b0;
        wait_deb(2, 1'b0, 40, n);
        chk("t5_release_latency", n, 18);
        chk("t5_v", int'(ev_v), 1);
        chk("t5_id", int'(ev_id), 2);
        chk("t5_type_overwritten", int'(ev_press), 0);
        chk("t5_overrun", int'(overrun), 1);
        step(2);
        ready = 1'b1;
        step(1);
        chk("t5_accepted", int'(ev_v), 0);
        chk("t5_overrun_sticky", int'(overrun), 1);

        // 6: reset in the middle of a count
        press[0] = 1'b1;
        step(11);
        chk("t6_model_cnt9", m_cnt[0], 9);
        rst = 1'b1;
        #1;
        chk("t6_async_deb", int'(debounced), 0);
        chk("t6_async_ev", int'(ev_v), 0);
        chk("t6_async_ovr", int'(overrun), 0);
        step(3);
        rst = 1'b0;
        wait_deb(0, 1'b1, 40, n);
        chk("t6_full_latency", n, 18);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
